// File: rtl/soc_status_pkg.sv
// Shared definitions for the EOC status block: FSM encoding, register
// offsets (relative to BASE_OFFSET) and CTRL bit positions.
package soc_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } status_state_e;

  localparam logic [11:0] OFF_EOC        = 12'h000;
  localparam logic [11:0] OFF_CYCLE_LO   = 12'h004;
  localparam logic [11:0] OFF_CYCLE_HI   = 12'h008;
  localparam logic [11:0] OFF_WDOG_LIMIT = 12'h00C;
  localparam logic [11:0] OFF_CTRL       = 12'h010;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CLEAR_BIT = 1;

endpackage

// File: rtl/status_wdog.sv
// Run watchdog: 32-bit up-counter that advances while run_i is high and
// flags expiry when the next count would reach limit_i.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   run_i        - FSM is in RUN
//   clear_i      - zero the counter (START or CLEAR)
//   limit_i      - watchdog limit, 0 disables
//   expire_o     - high during the last RUN cycle before the limit
module status_wdog (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  input  logic        clear_i,
  input  logic [31:0] limit_i,
  output logic        expire_o
);

  logic [31:0] wdog_q;
  logic [31:0] wdog_d;
  logic [31:0] wdog_inc;

  assign wdog_inc = wdog_q + 32'd1;

  always_comb begin
    wdog_d = wdog_q;
    if (clear_i) begin
      wdog_d = '0;
    end else if (run_i) begin
      wdog_d = wdog_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // Comparing wdog+1 lets DONE be entered on the edge that completes
  // exactly limit_i RUN cycles. The pulse lasts one cycle because the FSM
  // leaves RUN on that edge. A limit already passed only matches after wrap.
  assign expire_o = run_i && (limit_i != 32'd0) && (wdog_inc == limit_i);

endmodule

// File: rtl/soc_status_reg.sv
// APB end-of-computation status block: sticky done flag + 31-bit code,
// 64-bit run-cycle counter with read-coherent high half, and a watchdog
// that forces TIMEOUT_CODE if software never reports completion.
// Ports:
//   clk, reset             - system clock, async active-high reset
//   PSEL..PWDATA           - APB slave inputs (zero wait states)
//   PRDATA, PREADY, PSLVERR - APB slave outputs
//   eoc_o, eoc_code_o      - registered done flag and latched code
//   run_o                  - FSM currently in RUN
//
// state   | meaning
// --------+----------------------------------------------
// ST_IDLE | waiting for START; code writable
// ST_RUN  | counting cycles, watchdog armed
// ST_DONE | result latched; EOC writes ignored until CLEAR
module soc_status_reg
  import soc_status_pkg::*;
#(
  parameter logic [11:0] BASE_OFFSET  = 12'h0A0,
  parameter logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        eoc_o,
  output logic [30:0] eoc_code_o,
  output logic        run_o
);

  status_state_e state_q, state_d;
  logic          done_q, done_d;
  logic [30:0]   code_q, code_d;
  logic [63:0]   cnt_q, cnt_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   limit_q, limit_d;

  logic [11:0] off;
  logic        access, wr, rd;
  logic        sel_eoc, sel_lo, sel_hi, sel_lim, sel_ctrl, hit;
  logic        run;
  logic        wdog_clear;
  logic        expire;

  assign off    = PADDR - BASE_OFFSET;
  assign access = PSEL & PENABLE;
  assign wr     = access & PWRITE;
  assign rd     = access & ~PWRITE;

  assign sel_eoc  = (off == OFF_EOC);
  assign sel_lo   = (off == OFF_CYCLE_LO);
  assign sel_hi   = (off == OFF_CYCLE_HI);
  assign sel_lim  = (off == OFF_WDOG_LIMIT);
  assign sel_ctrl = (off == OFF_CTRL);
  assign hit      = sel_eoc | sel_lo | sel_hi | sel_lim | sel_ctrl;

  assign run = (state_q == ST_RUN);

  status_wdog u_wdog (
    .clk      (clk),
    .reset    (reset),
    .run_i    (run),
    .clear_i  (wdog_clear),
    .limit_i  (limit_q),
    .expire_o (expire)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    code_d     = code_q;
    cnt_d      = run ? (cnt_q + 64'd1) : cnt_q;
    shadow_d   = shadow_q;
    limit_d    = limit_q;
    wdog_clear = 1'b0;

    // Snapshot the high half with the low-half read so a 64-bit value
    // read as LO then HI is coherent.
    if (rd && sel_lo) begin
      shadow_d = cnt_q[63:32];
    end

    if (wr && sel_lim) begin
      limit_d = PWDATA;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (wr && sel_eoc && !PWDATA[31]) begin
          code_d = PWDATA[30:0];
        end
        if (wr && sel_ctrl && PWDATA[CTRL_START_BIT]) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          wdog_clear = 1'b1;
        end
      end
      ST_RUN: begin
        // Software done beats a coincident expiry; a code-only write
        // does not.
        if (wr && sel_eoc && PWDATA[31]) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          code_d  = PWDATA[30:0];
        end else if (expire) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          code_d  = TIMEOUT_CODE;
        end else if (wr && sel_eoc) begin
          code_d = PWDATA[30:0];
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (wr && sel_ctrl && PWDATA[CTRL_CLEAR_BIT]) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      code_d     = '0;
      cnt_d      = '0;
      shadow_d   = '0;
      wdog_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      code_q   <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      limit_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      limit_q  <= limit_d;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      if (sel_eoc)  PRDATA = {done_q, code_q};
      if (sel_lo)   PRDATA = cnt_q[31:0];
      if (sel_hi)   PRDATA = shadow_q;
      if (sel_lim)  PRDATA = limit_q;
      if (sel_ctrl) PRDATA = {30'b0, 1'b0, run};
    end
  end

  assign PREADY     = 1'b1;
  assign PSLVERR    = access & ~hit;
  assign eoc_o      = done_q;
  assign eoc_code_o = code_q;
  assign run_o      = run;

endmodule
